pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Decodes the D-stage instruction fields into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Supports stall, flush and bubble insertion, and flags illegal opcodes.
- With ENABLE_M=1, adds RV32M decode and a multi-cycle MUL/DIV occupancy FSM that holds the EX stage and raises a stall request to the hazard unit.
- Sits between the IF/ID register, the immediate extender, the hazard unit and the datapath stage muxes.

Parameters:
ENABLE_M, 1, 1 = decode RV32M (Op 0110011, funct7 0000001); 0 = treat it as illegal.
MD_LATENCY, 4, cycles a MUL/DIV instruction occupies EX (legal range 1..15; a value of 1 means no stall).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
Op  input  7  D-stage opcode.
funct7  input  7  D-stage funct7.
funct3  input  3  D-stage funct3.
StallD  input  1  hazard unit: hold D; insert bubble into ID/EX.
FlushE  input  1  hazard unit: clear ID/EX (bubble).
ImmSrcD  output  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U.
IllegalD  output  1  combinational: unsupported opcode/funct.
RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, MulDivE  output  1 each  EX control.
ResultSrcE  output  2  00 ALU, 01 mem, 10 PC+4.
ALU_CtrlE  output  4  ALU operation.
Funct3E  output  3  branch/load/store/MD sub-op.
RegWriteM, MemWriteM  output  1 each  MEM control.
ResultSrcM  output  2  MEM control.
RegWriteW  output  1  WB control.
ResultSrcW  output  2  WB control.
StallMD  output  1  combinational: EX is held by MUL/DIV.

Behaviour:
- Reset (rst=0, asynchronous): all E/M/W registered outputs are 0, the FSM is IDLE and the counter is 0.
- Decode (combinational on Op/funct):
  - R: RegWrite=1, ALUSrc=0.
  - I-ALU: RegWrite=1, ALUSrc=1, Imm=I.
  - Load: RegWrite=1, ALUSrc=1, ResultSrc=01.
  - Store: MemWrite=1, ALUSrc=1, Imm=S.
  - Branch: Branch=1, ALU=sub, Imm=B.
  - JAL: Jump=1, RegWrite=1, ResultSrc=10, Imm=J.
  - JALR: same as JAL but ALUSrc=1, Imm=I.
  - LUI: RegWrite=1, ALU=passB, Imm=U.
  - AUIPC: RegWrite=1, ALUSrc=1, Imm=U, ALU=add (PC operand selected by the datapath).
- ALU_Ctrl codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
  - funct7[5] selects sub only for R-type funct3=000; addi never selects sub.
  - funct7[5] selects sra for both R and I forms.
- M-extension decode: MulDiv=1, RegWrite=1, ALU_Ctrl=0000.
- Illegal instruction: IllegalD=1 and a zero bundle (no RegWrite/MemWrite/Branch/Jump).
- ID/EX update per clock, in priority order: StallMD → hold; FlushE or StallD → zero bundle; otherwise load the decode.
- EX/MEM update: StallMD → zero bundle (bubble); otherwise load from EX.
- MEM/WB always advances.
- MUL/DIV FSM:
  - IDLE: if MulDivE && MD_LATENCY>1, then StallMD=1 and next state is BUSY with cnt=1.
  - BUSY: cnt increments each cycle. StallMD = (cnt < MD_LATENCY-1). When cnt == MD_LATENCY-1, StallMD=0, the instruction advances, and the FSM returns to IDLE with cnt=0.
  - Net effect: the MUL/DIV holds EX for exactly MD_LATENCY cycles and reaches M exactly once.
- Back-to-back MUL/DIV: the second instruction enters EX the cycle after the first leaves and starts its own count from IDLE.
- FlushE/StallD while StallMD=1 are ignored for ID/EX. The hazard unit must keep D stalled using StallMD.
- Reset asserted mid-BUSY: FSM goes to IDLE immediately, all bundles are cleared, and no partial instruction reaches M.

Test Plan:
- Reset → all E/M/W outputs are 0, StallMD=0. Then a load (Op=0000011) → RegWriteE=1, ResultSrcE=01 on cycle 1; RegWriteW=1, ResultSrcW=01 on cycle 3.
- R-type sub (funct7=0100000, funct3=000) → ALU_CtrlE=0001. addi with funct7 bits set → 0000. srai (funct7[5]=1, funct3=101) → 1001.
- MUL (Op=0110011, funct7=0000001), MD_LATENCY=4 → StallMD=1 for 3 cycles, MulDivE held for 4 cycles, RegWriteM=1 for exactly 1 cycle. With ENABLE_M=0 → IllegalD=1 and RegWriteE=0.
- FlushE with a store in D → MemWriteE=0 next cycle. StallD with a JAL in D → JumpE=0.
- Two consecutive MULs with MD_LATENCY=2 → StallMD pattern 1,0,1,0; two M-stage writes, two cycles apart.
- rst pulsed low during BUSY (cnt=2) → outputs clear within the same cycle; after release, StallMD=0 and the FSM is IDLE.

Source files
------------

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - D-stage decode inputs and E/M/W control bundle outputs
// Purpose: groups the instruction fields, hazard controls and the pipelined
//          control outputs of pipelined_control_unit into one bundle.
// Signals:
//   Op, funct7, funct3   D-stage instruction fields
//   StallD, FlushE       hazard unit requests
//   ImmSrcD, IllegalD    combinational decode results
//   *E, *M, *W           registered control per pipeline stage
//   StallMD              EX held by a multi-cycle MUL/DIV
// Modports: master drives instruction/hazard inputs, slave is the control unit.
interface pipelined_control_unit_if;
    logic [6:0] Op;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       StallD;
    logic       FlushE;
    logic [2:0] ImmSrcD;
    logic       IllegalD;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       BranchE;
    logic       JumpE;
    logic       ALUSrcE;
    logic       MulDivE;
    logic [1:0] ResultSrcE;
    logic [3:0] ALU_CtrlE;
    logic [2:0] Funct3E;
    logic       RegWriteM;
    logic       MemWriteM;
    logic [1:0] ResultSrcM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;
    logic       StallMD;

    modport master (
        output Op, funct7, funct3, StallD, FlushE,
        input  ImmSrcD, IllegalD, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE,
               MulDivE, ResultSrcE, ALU_CtrlE, Funct3E, RegWriteM, MemWriteM,
               ResultSrcM, RegWriteW, ResultSrcW, StallMD
    );

    modport slave (
        input  Op, funct7, funct3, StallD, FlushE,
        output ImmSrcD, IllegalD, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE,
               MulDivE, ResultSrcE, ALU_CtrlE, Funct3E, RegWriteM, MemWriteM,
               ResultSrcM, RegWriteW, ResultSrcW, StallMD
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I(M) control decode with ID/EX, EX/MEM, MEM/WB control registers
// Purpose: decodes D-stage fields into a control bundle, pipelines it through
//          E/M/W, and holds EX for MD_LATENCY cycles on MUL/DIV.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  pipelined_control_unit_if.slave (decode inputs, stage controls, StallMD)
module pipelined_control_unit #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MD_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    pipelined_control_unit_if.slave   bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Last BUSY count value; EX is released on the cycle the counter reaches it.
    localparam logic [3:0] LP_LAST  = 4'(MD_LATENCY - 1);
    localparam bit         LP_MULTI = (MD_LATENCY > 1);

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       br;
        logic       j;
        logic       asrc;
        logic       md;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [2:0] f3;
    } ctrl_t;

    typedef enum logic {S_IDLE, S_BUSY} md_state_t;

    ctrl_t      w_dec;
    logic [2:0] w_imm;
    logic       w_ill;
    logic [3:0] w_alu;
    logic       w_is_r;

    ctrl_t      r_e;
    logic       r_m_rw;
    logic       r_m_mw;
    logic [1:0] r_m_rs;
    logic       r_w_rw;
    logic [1:0] r_w_rs;

    md_state_t  r_state;
    md_state_t  w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_stall;

    assign w_is_r = (bus.Op == OP_R);

    // funct3 -> ALU op; sub only for R-type, sra for both R and I shifts.
    always_comb begin
        w_alu = 4'b0000;
        case (bus.funct3)
            3'b000: w_alu = (w_is_r && bus.funct7[5]) ? 4'b0001 : 4'b0000;
            3'b001: w_alu = 4'b0111;
            3'b010: w_alu = 4'b0101;
            3'b011: w_alu = 4'b0110;
            3'b100: w_alu = 4'b0100;
            3'b101: w_alu = bus.funct7[5] ? 4'b1001 : 4'b1000;
            3'b110: w_alu = 4'b0011;
            3'b111: w_alu = 4'b0010;
            default: w_alu = 4'b0000;
        endcase
    end

    always_comb begin
        w_dec = '0;
        w_imm = 3'b000;
        w_ill = 1'b0;
        case (bus.Op)
            OP_R: begin
                if (bus.funct7 == 7'b0000000 ||
                    (bus.funct7 == 7'b0100000 && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101))) begin
                    w_dec.rw  = 1'b1;
                    w_dec.alu = w_alu;
                end else if (ENABLE_M && bus.funct7 == 7'b0000001) begin
                    w_dec.rw = 1'b1;
                    w_dec.md = 1'b1;
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_I: begin
                w_dec.rw   = 1'b1;
                w_dec.asrc = 1'b1;
                w_dec.alu  = w_alu;
            end
            OP_LOAD: begin
                w_dec.rw   = 1'b1;
                w_dec.asrc = 1'b1;
                w_dec.rs   = 2'b01;
            end
            OP_STORE: begin
                w_dec.mw   = 1'b1;
                w_dec.asrc = 1'b1;
                w_imm      = 3'b001;
            end
            OP_BRANCH: begin
                w_dec.br  = 1'b1;
                w_dec.alu = 4'b0001;
                w_imm     = 3'b010;
            end
            OP_JAL: begin
                w_dec.j  = 1'b1;
                w_dec.rw = 1'b1;
                w_dec.rs = 2'b10;
                w_imm    = 3'b011;
            end
            OP_JALR: begin
                w_dec.j    = 1'b1;
                w_dec.rw   = 1'b1;
                w_dec.rs   = 2'b10;
                w_dec.asrc = 1'b1;
            end
            OP_LUI: begin
                w_dec.rw  = 1'b1;
                w_dec.alu = 4'b1010;
                w_imm     = 3'b100;
            end
            OP_AUIPC: begin
                w_dec.rw   = 1'b1;
                w_dec.asrc = 1'b1;
                w_imm      = 3'b100;
            end
            default: w_ill = 1'b1;
        endcase
        if (!w_ill) begin
            w_dec.f3 = bus.funct3;
        end
    end

    // MUL/DIV occupancy: the IDLE cycle counts as the first EX cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_e.md && LP_MULTI) begin
                    w_stall      = 1'b1;
                    w_state_next = S_BUSY;
                    w_cnt_next   = 4'd1;
                end
            end
            S_BUSY: begin
                if (r_cnt == LP_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_e     <= '0;
            r_m_rw  <= 1'b0;
            r_m_mw  <= 1'b0;
            r_m_rs  <= 2'b00;
            r_w_rw  <= 1'b0;
            r_w_rs  <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // A held MUL/DIV owns EX; hazard requests are ignored until it leaves.
            if (!w_stall) begin
                r_e <= (bus.FlushE || bus.StallD) ? '0 : w_dec;
            end
            r_m_rw <= w_stall ? 1'b0  : r_e.rw;
            r_m_mw <= w_stall ? 1'b0  : r_e.mw;
            r_m_rs <= w_stall ? 2'b00 : r_e.rs;
            r_w_rw <= r_m_rw;
            r_w_rs <= r_m_rs;
        end
    end

    assign bus.ImmSrcD    = w_imm;
    assign bus.IllegalD   = w_ill;
    assign bus.StallMD    = w_stall;
    assign bus.RegWriteE  = r_e.rw;
    assign bus.MemWriteE  = r_e.mw;
    assign bus.BranchE    = r_e.br;
    assign bus.JumpE      = r_e.j;
    assign bus.ALUSrcE    = r_e.asrc;
    assign bus.MulDivE    = r_e.md;
    assign bus.ResultSrcE = r_e.rs;
    assign bus.ALU_CtrlE  = r_e.alu;
    assign bus.Funct3E    = r_e.f3;
    assign bus.RegWriteM  = r_m_rw;
    assign bus.MemWriteM  = r_m_mw;
    assign bus.ResultSrcM = r_m_rs;
    assign bus.RegWriteW  = r_w_rw;
    assign bus.ResultSrcW = r_w_rs;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - scoreboard bench for pipelined_control_unit (three parameter sets)
module tb_pipelined_control_unit;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       br;
        logic       j;
        logic       asrc;
        logic       md;
        logic [1:0] rs;
        logic [3:0] alu;
        logic [2:0] f3;
    } ex_t;

    typedef struct packed {
        logic       ill;
        logic [2:0] imm;
        ex_t        b;
    } dec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] s_op = 7'd0;
    logic [6:0] s_f7 = 7'd0;
    logic [2:0] s_f3 = 3'd0;
    logic       s_sd = 1'b0;
    logic       s_fe = 1'b0;

    logic [2:0][26:0] got;

    pipelined_control_unit_if ifs[3] ();

    // dut0: M enabled, latency 4; dut1: M disabled; dut2: M enabled, latency 2
    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ifs[g].Op     = s_op;
        assign ifs[g].funct7 = s_f7;
        assign ifs[g].funct3 = s_f3;
        assign ifs[g].StallD = s_sd;
        assign ifs[g].FlushE = s_fe;

        pipelined_control_unit #(
            .ENABLE_M   (g != 1),
            .MD_LATENCY (g == 2 ? 2 : 4)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifs[g])
        );

        assign got[g] = {ifs[g].ImmSrcD, ifs[g].IllegalD, ifs[g].StallMD,
                         ifs[g].RegWriteE, ifs[g].MemWriteE, ifs[g].BranchE, ifs[g].JumpE,
                         ifs[g].ALUSrcE, ifs[g].MulDivE, ifs[g].ResultSrcE, ifs[g].ALU_CtrlE,
                         ifs[g].Funct3E, ifs[g].RegWriteM, ifs[g].MemWriteM, ifs[g].ResultSrcM,
                         ifs[g].RegWriteW, ifs[g].ResultSrcW};
    end

    always #5 clk = ~clk;

    // Reference state: contents of each stage plus remaining EX occupancy.
    ex_t  me  [3];
    ex_t  mm  [3];
    ex_t  mwb [3];
    int   rem [3];
    bit   en_m [3] = '{1'b1, 1'b0, 1'b1};
    int   lat  [3] = '{4, 4, 2};

    logic [26:0] q [3][$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    function automatic dec_t ref_dec(input logic [6:0] op, input logic [6:0] f7,
                                     input logic [2:0] f3, input bit enm);
        dec_t       d;
        logic [3:0] alu_tab [8];
        logic [3:0] a;
        alu_tab = '{4'b0000, 4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b1000, 4'b0011, 4'b0010};
        a = alu_tab[f3];
        if (f3 == 3'b101 && f7[5]) a = 4'b1001;
        d = '0;
        case (op)
            OP_R: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    d.b.rw  = 1'b1;
                    d.b.alu = (f3 == 3'b000 && f7[5]) ? 4'b0001 : a;
                end else if (enm && f7 == 7'h01) begin
                    d.b.rw = 1'b1;
                    d.b.md = 1'b1;
                end else d.ill = 1'b1;
            end
            OP_I:      begin d.b.rw = 1'b1; d.b.asrc = 1'b1; d.b.alu = a; end
            OP_LOAD:   begin d.b.rw = 1'b1; d.b.asrc = 1'b1; d.b.rs = 2'b01; end
            OP_STORE:  begin d.b.mw = 1'b1; d.b.asrc = 1'b1; d.imm = 3'b001; end
            OP_BRANCH: begin d.b.br = 1'b1; d.b.alu = 4'b0001; d.imm = 3'b010; end
            OP_JAL:    begin d.b.j = 1'b1; d.b.rw = 1'b1; d.b.rs = 2'b10; d.imm = 3'b011; end
            OP_JALR:   begin d.b.j = 1'b1; d.b.rw = 1'b1; d.b.rs = 2'b10; d.b.asrc = 1'b1; end
            OP_LUI:    begin d.b.rw = 1'b1; d.b.alu = 4'b1010; d.imm = 3'b100; end
            OP_AUIPC:  begin d.b.rw = 1'b1; d.b.asrc = 1'b1; d.imm = 3'b100; end
            default:   d.ill = 1'b1;
        endcase
        if (!d.ill) d.b.f3 = f3;
        return d;
    endfunction

    function automatic logic [26:0] expect_of(input int i);
        dec_t d;
        logic st;
        d  = ref_dec(s_op, s_f7, s_f3, en_m[i]);
        st = me[i].md && (rem[i] > 1);
        return {d.imm, d.ill, st, me[i], mm[i].rw, mm[i].mw, mm[i].rs, mwb[i].rw, mwb[i].rs};
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            me[i] = '0; mm[i] = '0; mwb[i] = '0; rem[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                me[i] = '0; mm[i] = '0; mwb[i] = '0; rem[i] = 0;
            end else begin
                logic st;
                st     = me[i].md && (rem[i] > 1);
                mwb[i] = mm[i];
                mm[i]  = st ? ex_t'(0) : me[i];
                if (st) begin
                    rem[i] = rem[i] - 1;
                end else begin
                    me[i]  = (s_sd || s_fe) ? ex_t'(0) : ref_dec(s_op, s_f7, s_f3, en_m[i]).b;
                    rem[i] = me[i].md ? lat[i] : 0;
                end
            end
        end
    endtask

    // One cycle: clock edge, then new D-stage inputs and reset level, then expectations.
    task automatic step(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                        input logic sd, input logic fe, input logic r);
        @(posedge clk);
        #1;
        model_edge();
        s_op = op; s_f7 = f7; s_f3 = f3; s_sd = sd; s_fe = fe;
        rst = r;
        if (!r) clear_all();
        for (int i = 0; i < 3; i++) q[i].push_back(expect_of(i));
    endtask

    task automatic nop(input int n);
        for (int k = 0; k < n; k++) step(OP_I, 7'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        logic [26:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (q[i].size() != 0) begin
                    e = q[i].pop_front();
                    n_chk++;
                    if (got[i] === e) n_pass++;
                    else $display("FAIL dut%0d_outputs cycle %0d got=%h exp=%h", i, cyc, got[i], e);
                end
            end
        end
    end

    initial begin : stimulus
        logic [6:0] ops [9];
        logic [6:0] f7;
        int         pick;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        clear_all();
        // Reset state, then release with a load in D
        step(OP_I, 7'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        step(OP_LOAD, 7'h00, 3'b010, 1'b0, 1'b0, 1'b1);
        nop(3);
        // ALU control corner cases: sub, addi with funct7 bits, srai
        step(OP_R, 7'b0100000, 3'b000, 1'b0, 1'b0, 1'b1);
        step(OP_I, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        step(OP_I, 7'b0100000, 3'b101, 1'b0, 1'b0, 1'b1);
        nop(2);
        // Single MUL
        step(OP_R, 7'b0000001, 3'b000, 1'b0, 1'b0, 1'b1);
        nop(7);
        // FlushE with store, StallD with JAL
        step(OP_STORE, 7'h00, 3'b010, 1'b0, 1'b1, 1'b1);
        step(OP_JAL, 7'h00, 3'b000, 1'b1, 1'b0, 1'b1);
        nop(3);
        // Back-to-back MULs held in D while EX is busy
        for (int k = 0; k < 3; k++) step(OP_R, 7'b0000001, 3'b001, 1'b0, 1'b0, 1'b1);
        nop(8);
        // Reset mid-BUSY
        step(OP_R, 7'b0000001, 3'b100, 1'b0, 1'b0, 1'b1);
        nop(2);
        step(OP_I, 7'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        step(OP_I, 7'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        nop(4);
        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            pick = int'($urandom_range(0, 10));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            step((pick < 9) ? ops[pick] : 7'($urandom), f7, 3'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b1);
        end
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (q[i].size() == 0) n_pass++;
            else $display("FAIL dut%0d_drain pending=%0d required=0", i, q[i].size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
